// File: rtl/algo_fl_pkg.sv
// rtl/algo_fl_pkg.sv - shared types and helpers for the free-list allocator
// Purpose: FSM state enum, clog2 helper and modulo pointer wrap.
// Ports: none (package).
package algo_fl_pkg;

  typedef enum logic {FL_INIT, FL_RUN} fl_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Depth need not be a power of two, so wrap with an explicit compare.
  // inc is never larger than numaddr.
  function automatic int fl_wrap(input int ptr, input int inc, input int numaddr);
    int s;
    s = ptr + inc;
    if (s >= numaddr) s = s - numaddr;
    return s;
  endfunction

endpackage

// File: rtl/algo_fl_prio_sel.sv
// rtl/algo_fl_prio_sel.sv - lowest-index-first pop selector
// Purpose: grants needing ports in ascending order up to the available count.
// Ports:
//   need  in  NUMWRPT          ports requesting a fresh address
//   avail in  BITCNT           entries available to pop this cycle
//   grant out NUMWRPT          ports served this cycle
//   off   out NUMWRPT*BITCNT   pop offset from head for each granted port
//   npop  out BITCNT           number of grants
module algo_fl_prio_sel #(
  parameter int NUMWRPT = 8,
  parameter int BITCNT  = 9
) (
  input  logic [NUMWRPT-1:0]        need,
  input  logic [BITCNT-1:0]         avail,
  output logic [NUMWRPT-1:0]        grant,
  output logic [NUMWRPT*BITCNT-1:0] off,
  output logic [BITCNT-1:0]         npop
);

  always_comb begin
    grant = '0;
    off   = '0;
    npop  = '0;
    for (int i = 0; i < NUMWRPT; i++) begin
      if (need[i] && (npop < avail)) begin
        grant[i]                 = 1'b1;
        off[i*BITCNT +: BITCNT]  = npop;
        npop                     = npop + BITCNT'(1);
      end
    end
  end

endmodule

// File: rtl/algo_nm_fl_alloc.sv
// rtl/algo_nm_fl_alloc.sv - multi-port free-list address allocator
// Purpose: hands each malloc port a prefetched address from a circular free
// list and recycles addresses returned on the free ports.
// Optional: define ALGO_FL_DBLFREE_CHK_EN to drop double/unknown frees and
// report them on dbl_free.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   ready      free list initialised
//   ma_write   per-port consume strobe
//   ma_adr     per-port prefetched address (valid when ma_bp bit is 0)
//   ma_bp      per-port backpressure (1 = no address held)
//   fr_vld     per free port strobe
//   fr_adr     per free port returned address
//   fl_cnt     entries in the free list, excluding port slots
//   fl_empty   fl_cnt == 0
//   err_ovf    sticky: a push was dropped because the list was full
//   dbl_free   (optional) one-cycle pulse when a free was rejected
module algo_nm_fl_alloc
  import algo_fl_pkg::*;
#(
  parameter int NUMADDR = 256,
  parameter int BITADDR = 8,
  parameter int NUMWRPT = 8,
  parameter int NUMFRPT = 1,
  parameter int BITCNT  = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       ready,
  input  logic [NUMWRPT-1:0]         ma_write,
  output logic [NUMWRPT*BITADDR-1:0] ma_adr,
  output logic [NUMWRPT-1:0]         ma_bp,
  input  logic [NUMFRPT-1:0]         fr_vld,
  input  logic [NUMFRPT*BITADDR-1:0] fr_adr,
  output logic [BITCNT-1:0]          fl_cnt,
  output logic                       fl_empty,
`ifdef ALGO_FL_DBLFREE_CHK_EN
  output logic                       dbl_free,
`endif
  output logic                       err_ovf
);

  fl_state_e state, state_next;

  logic [BITADDR-1:0] free_q [NUMADDR];
  logic [BITADDR-1:0] hd, tl, ic;
  logic [NUMWRPT-1:0] slot_vld;
  logic [BITADDR-1:0] slot_adr [NUMWRPT];

  logic                      run;
  logic [NUMWRPT-1:0]        consume, need, grant;
  logic [NUMWRPT*BITCNT-1:0] off;
  logic [BITCNT-1:0]         npop, npush, base, fl_cnt_next;
  logic [BITADDR-1:0]        pop_idx  [NUMWRPT];
  logic [BITADDR-1:0]        push_idx [NUMFRPT];
  logic [NUMFRPT-1:0]        push_we;
  logic                      ovf_now;
  logic                      fr_ok;

`ifdef ALGO_FL_DBLFREE_CHK_EN
  logic [NUMADDR-1:0] alloc_map, set_mask, clr_mask;
  logic               dbl_now;
`endif

  assign run = (state == FL_RUN);

  always_ff @(posedge clk) begin
    if (rst) state <= FL_INIT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == FL_INIT && ic == BITADDR'(NUMADDR - 1)) state_next = FL_RUN;
  end

  assign consume = ma_write & slot_vld;
  assign need    = ~slot_vld | consume;

  // Pops are capped at the registered count, so this cycle's pushes wait.
  algo_fl_prio_sel #(
    .NUMWRPT (NUMWRPT),
    .BITCNT  (BITCNT)
  ) u_sel (
    .need  (need),
    .avail (fl_cnt),
    .grant (grant),
    .off   (off),
    .npop  (npop)
  );

  always_comb begin
    for (int i = 0; i < NUMWRPT; i++) begin
      pop_idx[i] = BITADDR'(fl_wrap(int'(hd), int'(off[i*BITCNT +: BITCNT]), NUMADDR));
    end
  end

  // Frees append at the tail in port order; anything that would take the
  // list past NUMADDR entries is dropped.
  always_comb begin
    npush   = '0;
    ovf_now = 1'b0;
    fr_ok   = 1'b0;
    push_we = '0;
    base    = fl_cnt - npop;
    for (int j = 0; j < NUMFRPT; j++) push_idx[j] = '0;
`ifdef ALGO_FL_DBLFREE_CHK_EN
    dbl_now  = 1'b0;
    clr_mask = '0;
    set_mask = '0;
    for (int i = 0; i < NUMWRPT; i++) begin
      if (run && consume[i]) set_mask[slot_adr[i]] = 1'b1;
    end
`endif
    for (int j = 0; j < NUMFRPT; j++) begin
      fr_ok = run && fr_vld[j];
`ifdef ALGO_FL_DBLFREE_CHK_EN
      if (fr_ok) begin
        if (!alloc_map[fr_adr[j*BITADDR +: BITADDR]]) fr_ok = 1'b0;
        for (int k = 0; k < j; k++) begin
          if (fr_vld[k] && fr_adr[k*BITADDR +: BITADDR] == fr_adr[j*BITADDR +: BITADDR])
            fr_ok = 1'b0;
        end
        if (!fr_ok) dbl_now = 1'b1;
      end
`endif
      if (fr_ok) begin
        if ((base + npush) >= BITCNT'(NUMADDR)) begin
          ovf_now = 1'b1;
        end else begin
          push_we[j]  = 1'b1;
          push_idx[j] = BITADDR'(fl_wrap(int'(tl), int'(npush), NUMADDR));
          npush       = npush + BITCNT'(1);
`ifdef ALGO_FL_DBLFREE_CHK_EN
          clr_mask[fr_adr[j*BITADDR +: BITADDR]] = 1'b1;
`endif
        end
      end
    end
  end

  assign fl_cnt_next = base + npush;

  always_ff @(posedge clk) begin
    if (rst) begin
      ic       <= '0;
      hd       <= '0;
      tl       <= '0;
      fl_cnt   <= '0;
      fl_empty <= 1'b1;
      ready    <= 1'b0;
      err_ovf  <= 1'b0;
      slot_vld <= '0;
      for (int i = 0; i < NUMWRPT; i++) slot_adr[i] <= '0;
`ifdef ALGO_FL_DBLFREE_CHK_EN
      alloc_map <= '0;
      dbl_free  <= 1'b0;
`endif
    end else if (!run) begin
      free_q[ic] <= ic;
      ic         <= ic + BITADDR'(1);
      tl         <= BITADDR'(fl_wrap(int'(tl), 1, NUMADDR));
      fl_cnt     <= fl_cnt + BITCNT'(1);
      fl_empty   <= 1'b0;
      ready      <= (state_next == FL_RUN);
    end else begin
      for (int i = 0; i < NUMWRPT; i++) begin
        if (grant[i]) begin
          slot_vld[i] <= 1'b1;
          slot_adr[i] <= free_q[pop_idx[i]];
        end else if (need[i]) begin
          slot_vld[i] <= 1'b0;
        end
      end
      for (int j = 0; j < NUMFRPT; j++) begin
        if (push_we[j]) free_q[push_idx[j]] <= fr_adr[j*BITADDR +: BITADDR];
      end
      hd       <= BITADDR'(fl_wrap(int'(hd), int'(npop), NUMADDR));
      tl       <= BITADDR'(fl_wrap(int'(tl), int'(npush), NUMADDR));
      fl_cnt   <= fl_cnt_next;
      fl_empty <= (fl_cnt_next == '0);
      if (ovf_now) err_ovf <= 1'b1;
`ifdef ALGO_FL_DBLFREE_CHK_EN
      alloc_map <= (alloc_map & ~clr_mask) | set_mask;
      dbl_free  <= dbl_now;
`endif
    end
  end

  always_comb begin
    for (int i = 0; i < NUMWRPT; i++) ma_adr[i*BITADDR +: BITADDR] = slot_adr[i];
  end
  assign ma_bp = ~slot_vld;

endmodule

// File: tb/tb_algo_nm_fl_alloc.sv
// tb/tb_algo_nm_fl_alloc.sv - self-checking bench for algo_nm_fl_alloc
module tb_algo_nm_fl_alloc;

  localparam int NA = 16;
  localparam int BA = 4;
  localparam int NW = 4;
  localparam int NF = 2;
  localparam int BC = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            ready;
  logic [NW-1:0]   ma_write;
  logic [NW*BA-1:0] ma_adr;
  logic [NW-1:0]   ma_bp;
  logic [NF-1:0]   fr_vld;
  logic [NF*BA-1:0] fr_adr;
  logic [BC-1:0]   fl_cnt;
  logic            fl_empty;
  logic            err_ovf;
`ifdef ALGO_FL_DBLFREE_CHK_EN
  logic            dbl_free;
`endif

  always #5 clk = ~clk;

  algo_nm_fl_alloc #(
    .NUMADDR (NA), .BITADDR (BA), .NUMWRPT (NW), .NUMFRPT (NF), .BITCNT (BC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .ma_write (ma_write),
    .ma_adr   (ma_adr),
    .ma_bp    (ma_bp),
    .fr_vld   (fr_vld),
    .fr_adr   (fr_adr),
    .fl_cnt   (fl_cnt),
    .fl_empty (fl_empty),
`ifdef ALGO_FL_DBLFREE_CHK_EN
    .dbl_free (dbl_free),
`endif
    .err_ovf  (err_ovf)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: a queue of free addresses plus per-port slots.
  int q[$];
  int m_ic, m_navail, m_npop, fa;
  bit m_ready, m_err, m_dbl, m_dup;
  bit m_v [NW];
  int m_a [NW];
  int m_old_a [NW];
  bit m_cons [NW];
  bit m_alloc [NA];

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_ic = 0; m_ready = 0; m_err = 0; m_dbl = 0;
      for (int i = 0; i < NW; i++) begin m_v[i] = 0; m_a[i] = 0; end
      for (int a = 0; a < NA; a++) m_alloc[a] = 0;
    end else if (!m_ready) begin
      q.push_back(m_ic);
      m_ic++;
      if (m_ic == NA) m_ready = 1;
      m_dbl = 0;
    end else begin
      m_navail = q.size();
      m_npop = 0;
      for (int i = 0; i < NW; i++) begin
        m_old_a[i] = m_a[i];
        m_cons[i]  = ma_write[i] && m_v[i];
        if (!m_v[i] || m_cons[i]) begin
          if (m_npop < m_navail) begin
            m_a[i] = q.pop_front();
            m_v[i] = 1;
            m_npop++;
          end else begin
            m_v[i] = 0;
          end
        end
      end
      m_dbl = 0;
      for (int j = 0; j < NF; j++) begin
        if (fr_vld[j]) begin
          fa = int'(fr_adr[j*BA +: BA]);
`ifdef ALGO_FL_DBLFREE_CHK_EN
          m_dup = 0;
          for (int k = 0; k < j; k++)
            if (fr_vld[k] && int'(fr_adr[k*BA +: BA]) == fa) m_dup = 1;
          if (!m_alloc[fa] || m_dup) begin
            m_dbl = 1;
            continue;
          end
`endif
          if (q.size() >= NA) m_err = 1;
          else begin
            q.push_back(fa);
            m_alloc[fa] = 0;
          end
        end
      end
`ifdef ALGO_FL_DBLFREE_CHK_EN
      for (int i = 0; i < NW; i++) if (m_cons[i]) m_alloc[m_old_a[i]] = 1;
`endif
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("ready", int'(ready), int'(m_ready));
      check("fl_cnt", int'(fl_cnt), q.size());
      check("fl_empty", int'(fl_empty), int'(q.size() == 0));
      check("err_ovf", int'(err_ovf), int'(m_err));
      for (int i = 0; i < NW; i++) begin
        check("ma_bp", int'(ma_bp[i]), int'(!m_v[i]));
        if (m_v[i]) check("ma_adr", int'(ma_adr[i*BA +: BA]), m_a[i]);
      end
`ifdef ALGO_FL_DBLFREE_CHK_EN
      check("dbl_free", int'(dbl_free), int'(m_dbl));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1; ma_write = '0; fr_vld = '0; fr_adr = '0;
    tick();
    chk_en = 1;
    tick();
    check("rst_ready", int'(ready), 0);
    check("rst_bp", int'(ma_bp), 4'hF);
    check("rst_adr", int'(ma_adr), 0);
    check("rst_cnt", int'(fl_cnt), 0);
    check("rst_empty", int'(fl_empty), 1);
    check("rst_ovf", int'(err_ovf), 0);
    rst = 0;
    repeat (15) tick();
    check("init15_ready", int'(ready), 0);
    tick();
    check("init16_ready", int'(ready), 1);
    check("init16_cnt", int'(fl_cnt), 16);
    tick();
    check("prefetch_bp", int'(ma_bp), 0);
    check("prefetch_adr", int'(ma_adr), 16'h3210);
    check("prefetch_cnt", int'(fl_cnt), 12);

    ma_write = 4'hF;
    tick();
    check("drain1_adr", int'(ma_adr), 16'h7654);
    check("drain1_cnt", int'(fl_cnt), 8);
    tick();
    check("drain2_adr", int'(ma_adr), 16'hBA98);
    tick();
    check("drain3_adr", int'(ma_adr), 16'hFEDC);
    check("drain3_empty", int'(fl_empty), 1);
    tick();
    check("drain4_bp", int'(ma_bp), 4'hF);
    check("drain4_empty", int'(fl_empty), 1);
    ma_write = '0;

    fr_vld = 2'b01; fr_adr = 8'h05;
    tick();
    check("free5_cnt", int'(fl_cnt), 1);
    fr_vld = '0;
    tick();
    check("free5_bp", int'(ma_bp), 4'b1110);
    check("free5_adr", int'(ma_adr[3:0]), 5);
    check("free5_cnt0", int'(fl_cnt), 0);

    ma_write = 4'b0100;
    tick();
    check("bpwrite_cnt", int'(fl_cnt), 0);
    check("bpwrite_bp", int'(ma_bp), 4'b1110);
    check("bpwrite_ovf", int'(err_ovf), 0);
    ma_write = '0;

    fr_vld = 2'b11; fr_adr = 8'h29;
    tick();
    check("free2_cnt", int'(fl_cnt), 2);
    fr_vld = '0;
    tick();
    check("free2_bp", int'(ma_bp), 4'b1000);
    check("free2_p1", int'(ma_adr[7:4]), 9);
    check("free2_p2", int'(ma_adr[11:8]), 2);
    fr_vld = 2'b01; fr_adr = 8'h07;
    tick();
    fr_vld = '0;
    tick();
    check("full_slots", int'(ma_adr), 16'h7295);

`ifndef ALGO_FL_DBLFREE_CHK_EN
    for (int c = 0; c < 8; c++) begin
      fr_vld = 2'b11;
      fr_adr = {4'(2*c + 1), 4'(2*c)};
      tick();
    end
    check("fill_cnt", int'(fl_cnt), 16);
    check("fill_ovf", int'(err_ovf), 0);
    tick();
    check("ovf_set", int'(err_ovf), 1);
    check("ovf_cnt", int'(fl_cnt), 16);
    fr_vld = '0;
    repeat (3) tick();
    check("ovf_sticky", int'(err_ovf), 1);
`endif

    rst = 1;
    tick();
    check("rst2_ovf", int'(err_ovf), 0);
    check("rst2_bp", int'(ma_bp), 4'hF);
    check("rst2_ready", int'(ready), 0);
    rst = 0;
    repeat (17) tick();

`ifdef ALGO_FL_DBLFREE_CHK_EN
    ma_write = 4'b1000;
    tick();
    ma_write = '0;
    check("dbl_alloc_cnt", int'(fl_cnt), 11);
    fr_vld = 2'b01; fr_adr = 8'h03;
    tick();
    check("dbl_first_cnt", int'(fl_cnt), 12);
    check("dbl_first_pulse", int'(dbl_free), 0);
    tick();
    check("dbl_second_cnt", int'(fl_cnt), 12);
    check("dbl_second_pulse", int'(dbl_free), 1);
    fr_vld = '0;
    tick();
    check("dbl_pulse_end", int'(dbl_free), 0);
`endif

    for (int c = 0; c < 60; c++) begin
      ma_write = 4'($urandom);
      fr_vld   = 2'($urandom);
      fr_adr   = 8'($urandom);
      rst      = (c == 30 || c == 31);
      tick();
    end
    rst = 0; ma_write = '0; fr_vld = '0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/algo_nm_fl_alloc.md
Name: algo_nm_fl_alloc

Overview:
- Parametrised free-list address allocator for the multi-malloc-port algorithmic memories, generalising the fixed 8-port, global-backpressure allocator.
- Serves NUMWRPT allocation ports. Each port has its own prefetched address and its own backpressure.
- Recycles addresses through NUMFRPT free ports, driven by the read-dequeue path.
- Sits between the user malloc/dequeue interface and the memory core's write-address path.

Parameters:
- NUMADDR, 256, number of allocatable addresses (free-list depth).
- BITADDR, 8, address width (clog2 of NUMADDR).
- NUMWRPT, 8, number of malloc ports.
- NUMFRPT, 1, number of free (dequeue) ports.
- BITCNT, 9, count width (clog2 of NUMADDR+1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ready  out  1  high once free-list initialisation is complete.
- ma_write  in  NUMWRPT  per-port allocate/consume strobe.
- ma_adr  out  NUMWRPT*BITADDR  per-port prefetched address, valid when ma_bp[i]=0.
- ma_bp  out  NUMWRPT  per-port backpressure: 1 = no address held.
- fr_vld  in  NUMFRPT  free strobe per free port.
- fr_adr  in  NUMFRPT*BITADDR  address being returned.
- fl_cnt  out  BITCNT  entries currently in the free list, excluding port slots.
- fl_empty  out  1  fl_cnt==0.
- err_ovf  out  1  sticky: a push was dropped because the list was full.

Behaviour:
- Storage:
  - Circular register array free_q[NUMADDR], with head pointer hd, tail pointer tl and fl_cnt.
  - Per-port slot registers: slot_vld[i], slot_adr[i].
- States: INIT and RUN.
- Reset (rst=1 at an edge):
  - state=INIT, init counter ic=0, hd=tl=0, fl_cnt=0.
  - All slot_vld=0, so ma_bp=all ones and ma_adr=0.
  - ready=0, err_ovf=0, fl_empty=1.
  - Reset asserted mid-operation discards all outstanding state the same way. Addresses held downstream are forgotten.
- INIT:
  - One entry per cycle: free_q[ic]=ic, then ic++, tl++, fl_cnt++.
  - After entry NUMADDR-1 is written, move to RUN. ready=1 from the next cycle (NUMADDR cycles after reset release).
  - ma_write and fr_vld are ignored during INIT.
- RUN, per cycle:
  - consume[i] = ma_write[i] & slot_vld[i]. A write while ma_bp[i]=1 is ignored; no error is raised.
  - need[i] = !slot_vld[i] | consume[i].
  - Pops go to ports with need=1, lowest index first, capped at fl_cnt (the registered value).
  - The k-th popped port gets free_q[hd+k] (mod NUMADDR), and slot_vld is set at the edge. A port that consumes while an entry is available gets a new address the next cycle, giving 1 allocation per port per cycle.
  - A needing port left unserved gets slot_vld=0 and ma_bp=1 next cycle.
- Pushes:
  - Valid frees are appended at tl in ascending free-port order.
  - Entries pushed in a cycle are not poppable until the next cycle, since pops use registered fl_cnt.
  - If fl_cnt - npop + (pushes so far) would exceed NUMADDR, the excess pushes are dropped and err_ovf sets. err_ovf clears only on rst.
- Counters:
  - fl_cnt_next = fl_cnt - npop + npush_accepted.
  - hd and tl wrap modulo NUMADDR; NUMADDR need not be a power of two (explicit wrap compare).
  - All outputs are registered except that ma_adr/ma_bp come directly from slot registers.
- Invariant with no errors: fl_cnt + popcount(slot_vld) + (addresses held downstream) = NUMADDR.

Optional Feature:
- Macro: ALGO_FL_DBLFREE_CHK_EN.
- When defined:
  - A NUMADDR-bit allocated bitmap is kept. A bit is set when its address is consumed by ma_write and cleared on free.
  - A free of an address whose bit is 0, or a duplicate address within one cycle's free ports, is dropped (not pushed).
  - Such a drop pulses output dbl_free (1 bit, registered, reset 0) for one cycle.
- When undefined: no bitmap, no dbl_free port, and all frees are pushed subject only to the overflow rule.

Decomposition:
- Package algo_fl_pkg holds:
  - the state enum {FL_INIT, FL_RUN};
  - a clog2 helper function;
  - the pointer-wrap function fl_wrap(ptr, inc, NUMADDR).
- One sub-module, algo_fl_prio_sel: lowest-index-first selector. Given the need vector and an available count, it outputs a per-port grant vector and each granted port's pop offset.

Test Plan:
- Reset release, NUMADDR=16, NUMWRPT=4: ready rises at cycle 16. Next cycle ma_bp=4'b0000 and ma_adr={3,2,1,0} (port0=0), fl_cnt=12.
- All 4 ports write every cycle for 3 cycles: ports receive 4..7, then 8..11, then 12..15. In the 4th cycle ma_bp=4'hF and fl_empty=1.
- Empty list, fr_vld=1 with fr_adr=5: next cycle fl_cnt=1. The cycle after, port0 holds adr 5 with ma_bp[0]=0 and ports1-3 stay backpressured.
- ma_write[2]=1 while ma_bp[2]=1: no pop, fl_cnt unchanged, no error.
- Fill the list to NUMADDR with frees while slots are valid (forced double return): the extra push is dropped, err_ovf=1 and stays high until rst.
- With ALGO_FL_DBLFREE_CHK_EN: free adr 3 twice after one allocation. The first is accepted; the second pulses dbl_free for 1 cycle and fl_cnt grows by only 1.
